// File: rtl/timer_display_pkg.sv
// Shared types and constants for the MM:SS timer with a multiplexed
// four-digit seven-segment display.
//   bcd_t       - one BCD digit
//   seg_t       - active-low segment vector {g,f,e,d,c,b,a}
//   mmss_t      - packed BCD time, m1 (minutes tens) in the top nibble
//   run_state_t - run/pause state
// Helper functions: seg_of (digit -> segments), mmss_valid,
// mmss_inc and mmss_dec (BCD time step with carry/borrow).
package timer_display_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  typedef struct packed {
    bcd_t m1;
    bcd_t m0;
    bcd_t s1;
    bcd_t s0;
  } mmss_t;

  typedef enum logic {
    ST_PAUSED  = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Element n is the pattern for digit n (element 9 listed first).
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  localparam mmss_t MMSS_MAX = 16'h5959;

  function automatic seg_t seg_of(bcd_t d);
    if (d <= 4'd9) return SEG_TABLE[d];
    return SEG_BLANK;
  endfunction

  function automatic logic mmss_valid(mmss_t t);
    return (t.m1 <= 4'd5) && (t.m0 <= 4'd9) && (t.s1 <= 4'd5) && (t.s0 <= 4'd9);
  endfunction

  // 59:59 wraps to 00:00.
  function automatic mmss_t mmss_inc(mmss_t t);
    mmss_t r;
    r = t;
    if (t.s0 != 4'd9) r.s0 = t.s0 + 4'd1;
    else begin
      r.s0 = 4'd0;
      if (t.s1 != 4'd5) r.s1 = t.s1 + 4'd1;
      else begin
        r.s1 = 4'd0;
        if (t.m0 != 4'd9) r.m0 = t.m0 + 4'd1;
        else begin
          r.m0 = 4'd0;
          if (t.m1 != 4'd5) r.m1 = t.m1 + 4'd1;
          else              r.m1 = 4'd0;
        end
      end
    end
    return r;
  endfunction

  // 00:00 would wrap to 59:59, but the run logic never steps from 00:00.
  function automatic mmss_t mmss_dec(mmss_t t);
    mmss_t r;
    r = t;
    if (t.s0 != 4'd0) r.s0 = t.s0 - 4'd1;
    else begin
      r.s0 = 4'd9;
      if (t.s1 != 4'd0) r.s1 = t.s1 - 4'd1;
      else begin
        r.s1 = 4'd5;
        if (t.m0 != 4'd0) r.m0 = t.m0 - 4'd1;
        else begin
          r.m0 = 4'd9;
          if (t.m1 != 4'd0) r.m1 = t.m1 - 4'd1;
          else              r.m1 = 4'd5;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_display_if.sv
// Control and display bundle of the timer.
//   start_stop - one-cycle pulse, toggles run/pause
//   load       - one-cycle pulse, loads load_val when it is valid BCD MM:SS
//   load_val   - BCD MM:SS, [15:12] minutes tens
//   C          - active-low segments {g,f,e,d,c,b,a}
//   AN         - active-low digit enables, AN[3] leftmost
//   dp         - active-low colon
//   running    - high while counting
//   done       - terminal-count indication
// slave: the timer; master: whoever drives the controls.
interface timer_display_if;
  import timer_display_pkg::*;

  logic        start_stop;
  logic        load;
  logic [15:0] load_val;
  seg_t        C;
  logic [3:0]  AN;
  logic        dp;
  logic        running;
  logic        done;

  modport slave (
    input  start_stop, load, load_val,
    output C, AN, dp, running, done
  );

  modport master (
    output start_stop, load, load_val,
    input  C, AN, dp, running, done
  );

endinterface

// File: rtl/timer_display_tick_gen.sv
// Modulo-DIV cycle counter producing a single-cycle enable.
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   en    - count enable
//   clr   - synchronous clear to 0, overrides en
//   tick  - high while enabled and the count sits at DIV-1
//   count - current count value
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clr,
  output logic                   tick,
  output logic [$clog2(DIV)-1:0] count
);

  localparam int unsigned W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = (count_q == LAST) ? '0 : count_q + W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign tick  = en && (count_q == LAST);
  assign count = count_q;

endmodule

// File: rtl/timer_display.sv
// MM:SS up/down timer driving a multiplexed 4-digit seven-segment display.
//   clock - sole rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - control inputs and registered display/status outputs
// Parameters: SCAN_DIV cycles per digit step, SEC_DIV cycles per second,
// COUNT_DOWN selects direction, BLANK_LZ blanks a zero minutes-tens digit.
module timer_display
  import timer_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned SEC_DIV    = 100000000,
  parameter bit          COUNT_DOWN = 1'b0,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic           clock,
  input  logic           reset,
  timer_display_if.slave bus
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned SEC_W  = $clog2(SEC_DIV);
  localparam logic [SEC_W-1:0] SEC_HALF = SEC_W'(SEC_DIV / 2);

  run_state_t state_q, state_d;
  mmss_t      time_q, time_d;
  logic       done_q, done_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] an_q, an_d;
  seg_t       seg_q, seg_d;
  logic       dp_q, dp_d;

  logic              scan_tick;
  logic [SCAN_W-1:0] scan_cnt_unused;
  logic              sec_tick;
  logic              sec_clr;
  logic [SEC_W-1:0]  sec_cnt;
  logic              running;
  mmss_t             load_time;
  bcd_t              digit;

  assign running   = (state_q == ST_RUNNING);
  assign load_time = bus.load_val;

  tick_gen #(.DIV(SCAN_DIV)) u_scan (
    .clock (clock),
    .reset (reset),
    .en    (1'b1),
    .clr   (1'b0),
    .tick  (scan_tick),
    .count (scan_cnt_unused)
  );

  tick_gen #(.DIV(SEC_DIV)) u_sec (
    .clock (clock),
    .reset (reset),
    .en    (running),
    .clr   (sec_clr),
    .tick  (sec_tick),
    .count (sec_cnt)
  );

  // Run state and time. The if/else chain encodes load > start_stop >
  // sec_tick, so a tick coinciding with either control pulse is dropped.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    done_d  = COUNT_DOWN ? done_q : 1'b0;
    sec_clr = 1'b0;
    if (bus.load && mmss_valid(load_time)) begin
      time_d  = load_time;
      state_d = ST_PAUSED;
      done_d  = 1'b0;
      sec_clr = 1'b1;
    end else if (bus.start_stop && !(COUNT_DOWN && (time_q == '0))) begin
      state_d = running ? ST_PAUSED : ST_RUNNING;
      sec_clr = 1'b1;
    end else if (sec_tick) begin
      if (COUNT_DOWN) begin
        time_d = mmss_dec(time_q);
        if (time_d == '0) begin
          state_d = ST_PAUSED;
          done_d  = 1'b1;
        end
      end else begin
        time_d = mmss_inc(time_q);
        if (time_q == MMSS_MAX) done_d = 1'b1;
      end
    end
  end

  // Display scan; outputs are registered from the current index and time.
  always_comb begin
    idx_d = scan_tick ? idx_q + 2'd1 : idx_q;
    case (idx_q)
      2'd0:    digit = time_q.s0;
      2'd1:    digit = time_q.s1;
      2'd2:    digit = time_q.m0;
      default: digit = time_q.m1;
    endcase
    seg_d = seg_of(digit);
    if (BLANK_LZ && (idx_q == 2'd3) && (time_q.m1 == '0)) seg_d = SEG_BLANK;
    an_d = ~(4'b0001 << idx_q);
    dp_d = ~((idx_q == 2'd2) && (!running || (sec_cnt < SEC_HALF)));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_PAUSED;
      time_q  <= '0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.C       = seg_q;
  assign bus.AN      = an_q;
  assign bus.dp      = dp_q;
  assign bus.running = running;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_timer_display.sv
// Bench for timer_display: one count-up and one count-down instance,
// SCAN_DIV=4, SEC_DIV=10. Expected display contents come from a
// seconds-based model and are queued when stimulus is applied, then
// popped when a full display scan has been captured and decoded.
module tb_timer_display;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned SEC_DIV  = 10;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  timer_display_if bus_up ();
  timer_display_if bus_dn ();

  timer_display #(
    .SCAN_DIV(SCAN_DIV), .SEC_DIV(SEC_DIV), .COUNT_DOWN(1'b0), .BLANK_LZ(1'b1)
  ) u_dut_up (
    .clock (clock),
    .reset (reset),
    .bus   (bus_up)
  );

  timer_display #(
    .SCAN_DIV(SCAN_DIV), .SEC_DIV(SEC_DIV), .COUNT_DOWN(1'b1), .BLANK_LZ(1'b1)
  ) u_dut_dn (
    .clock (clock),
    .reset (reset),
    .bus   (bus_dn)
  );

  int n_checks = 0;
  int n_fail   = 0;

  string       exp_tag_q[$];
  logic [15:0] exp_val_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int to_sec(logic [15:0] b);
    return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] from_sec(int s);
    int m, ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Blank on the leftmost digit reads as 0; anything unknown reads as F.
  function automatic logic [3:0] seg_decode(logic [6:0] c, bit leftmost);
    case (c)
      7'b1000000: return 4'd0;
      7'b1111001: return 4'd1;
      7'b0100100: return 4'd2;
      7'b0110000: return 4'd3;
      7'b0011001: return 4'd4;
      7'b0010010: return 4'd5;
      7'b0000010: return 4'd6;
      7'b1111000: return 4'd7;
      7'b0000000: return 4'd8;
      7'b0010000: return 4'd9;
      7'b1111111: return leftmost ? 4'd0 : 4'hF;
      default:    return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] get_an(bit dn);
    return dn ? bus_dn.AN : bus_up.AN;
  endfunction
  function automatic logic [6:0] get_c(bit dn);
    return dn ? bus_dn.C : bus_up.C;
  endfunction
  function automatic logic get_dp(bit dn);
    return dn ? bus_dn.dp : bus_up.dp;
  endfunction
  function automatic logic get_run(bit dn);
    return dn ? bus_dn.running : bus_up.running;
  endfunction
  function automatic logic get_done(bit dn);
    return dn ? bus_dn.done : bus_up.done;
  endfunction

  task automatic push_exp(input string tag, input logic [15:0] v);
    exp_tag_q.push_back(tag);
    exp_val_q.push_back(v);
  endtask

  // All drive tasks start and end on a falling edge.
  task automatic drive(input bit dn, input bit ld, input logic [15:0] v, input bit ss);
    if (dn) begin
      bus_dn.load = ld; bus_dn.load_val = v; bus_dn.start_stop = ss;
    end else begin
      bus_up.load = ld; bus_up.load_val = v; bus_up.start_stop = ss;
    end
    @(negedge clock);
    bus_dn.load = 1'b0; bus_dn.start_stop = 1'b0;
    bus_up.load = 1'b0; bus_up.start_stop = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Returns the number of falling edges until done is seen, -1 if never.
  task automatic wait_done(input bit dn, input int bound, output int k);
    k = -1;
    for (int n = 1; n <= bound; n++) begin
      @(negedge clock);
      if (get_done(dn)) begin
        k = n;
        break;
      end
    end
  endtask

  // Capture one full scan while paused, decode it and compare against the
  // oldest queued expectation; the colon must be lit only on digit 2.
  task automatic read_display(input bit dn);
    logic [15:0] val;
    logic [3:0]  seen, dpv, an;
    string       tag;
    val  = '1;
    seen = '0;
    dpv  = '1;
    for (int n = 0; n < 40 && seen != 4'hF; n++) begin
      @(negedge clock);
      an = get_an(dn);
      for (int i = 0; i < 4; i++) begin
        if (an == ~(4'b0001 << i)) begin
          seen[i]        = 1'b1;
          val[i*4 +: 4]  = seg_decode(get_c(dn), i == 3);
          dpv[i]         = get_dp(dn);
        end
      end
    end
    check("scan_complete", seen, 4'hF);
    check("colon_paused", dpv, 4'b1011);
    if (exp_val_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      tag = exp_tag_q.pop_front();
      check(tag, val, exp_val_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int k, lo, hi;
    logic found;
    logic [3:0] exp_an;

    bus_up.start_stop = 1'b0; bus_up.load = 1'b0; bus_up.load_val = '0;
    bus_dn.start_stop = 1'b0; bus_dn.load = 1'b0; bus_dn.load_val = '0;
    reset = 1'b0;

    // Reset values
    cycles(3);
    check("rst_an", bus_up.AN, 4'hF);
    check("rst_c", bus_up.C, 7'h7F);
    check("rst_dp", bus_up.dp, 1'b1);
    check("rst_running", bus_up.running, 1'b0);
    check("rst_done", bus_up.done, 1'b0);
    check("rst_an_dn", bus_dn.AN, 4'hF);

    // Scenario 1: scan order and leading-zero blanking
    reset = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clock);
      if (bus_up.AN != 4'hF) found = 1'b1;
    end
    check("scan_start", found, 1'b1);
    for (int s = 0; s < 5; s++) begin
      exp_an = ~(4'b0001 << (s % 4));
      check("scan_an", bus_up.AN, exp_an);
      check("scan_c", bus_up.C, (s % 4 == 3) ? 7'b1111111 : 7'b1000000);
      check("scan_dp", bus_up.dp, (s % 4 == 2) ? 1'b0 : 1'b1);
      cycles(4);
    end
    push_exp("s1_time", 16'h0000);
    read_display(1'b0);
    check("s1_running", bus_up.running, 1'b0);

    // Scenario 2: carries; 19 running cycles give one tick, 20 give two
    drive(1'b0, 1'b1, 16'h0958, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    check("s2_running", bus_up.running, 1'b1);
    cycles(18);
    drive(1'b0, 1'b0, '0, 1'b1);
    push_exp("s2_after19", from_sec(to_sec(16'h0958) + 1));
    read_display(1'b0);

    drive(1'b0, 1'b1, 16'h0958, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    cycles(20);
    drive(1'b0, 1'b0, '0, 1'b1);
    push_exp("s2_after20", from_sec(to_sec(16'h0958) + 2));
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clock);
      if (bus_up.AN == 4'b0111) found = 1'b1;
    end
    check("s2_min_tens_seg", bus_up.C, 7'b1111001);
    read_display(1'b0);

    // Pause landing on the tick edge: the tick is dropped
    drive(1'b0, 1'b1, 16'h0958, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    cycles(9);
    drive(1'b0, 1'b0, '0, 1'b1);
    push_exp("s2_tick_vs_pause", 16'h0958);
    read_display(1'b0);

    // Scenario 3: count-up wrap at 59:59
    drive(1'b0, 1'b1, 16'h5959, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    wait_done(1'b0, 30, k);
    check("s3_done_latency", k, 10);
    check("s3_running_at_done", bus_up.running, 1'b1);
    @(negedge clock);
    check("s3_done_pulse", bus_up.done, 1'b0);
    check("s3_running_after", bus_up.running, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    push_exp("s3_wrap", from_sec((to_sec(16'h5959) + 1) % 3600));
    read_display(1'b0);

    // Scenario 4: count-down to zero, sticky done, start ignored
    drive(1'b1, 1'b1, 16'h0002, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b1);
    wait_done(1'b1, 40, k);
    check("s4_done_latency", k, 20);
    check("s4_running_cleared", bus_dn.running, 1'b0);
    cycles(5);
    check("s4_done_sticky", bus_dn.done, 1'b1);
    drive(1'b1, 1'b0, '0, 1'b1);
    cycles(2);
    check("s4_start_ignored", bus_dn.running, 1'b0);
    check("s4_done_kept", bus_dn.done, 1'b1);
    push_exp("s4_zero", from_sec(to_sec(16'h0002) - 2));
    read_display(1'b1);

    drive(1'b1, 1'b1, 16'h1000, 1'b0);
    check("s4_load_clears_done", bus_dn.done, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b1);
    cycles(10);
    drive(1'b1, 1'b0, '0, 1'b1);
    push_exp("s4_borrow", from_sec(to_sec(16'h1000) - 1));
    read_display(1'b1);

    // Scenario 5: rejected loads, load beats start_stop
    drive(1'b0, 1'b1, 16'h1234, 1'b0);
    drive(1'b0, 1'b1, 16'h0A00, 1'b0);
    drive(1'b0, 1'b1, 16'h0060, 1'b0);
    push_exp("s5_rejected", 16'h1234);
    read_display(1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    check("s5_running", bus_up.running, 1'b1);
    drive(1'b0, 1'b1, 16'h0100, 1'b1);
    check("s5_load_wins", bus_up.running, 1'b0);
    push_exp("s5_loaded", 16'h0100);
    read_display(1'b0);

    // Colon blinks while running: both halves of the second are seen
    drive(1'b0, 1'b0, '0, 1'b1);
    lo = 0;
    hi = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (bus_up.AN == 4'b1011) begin
        if (bus_up.dp) hi++;
        else           lo++;
      end
    end
    check("colon_lit_seen", lo != 0, 1'b1);
    check("colon_dark_seen", hi != 0, 1'b1);

    // Scenario 6: asynchronous reset 5 cycles into a second
    drive(1'b0, 1'b1, 16'h0030, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    cycles(5);
    #2 reset = 1'b0;
    #1;
    check("s6_an", bus_up.AN, 4'hF);
    check("s6_c", bus_up.C, 7'h7F);
    check("s6_dp", bus_up.dp, 1'b1);
    check("s6_running", bus_up.running, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    push_exp("s6_time", 16'h0000);
    read_display(1'b0);
    check("s6_running_after", bus_up.running, 1'b0);
    check("s6_done_after", bus_up.done, 1'b0);

    check("scoreboard_drained", exp_val_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
